// File: rtl/dvi_serdes_ctrl.sv
// dvi_serdes_ctrl: bring-up and supervision sequencer for the DVI TMDS serializers.
// Flow: IDLE -> WAIT_LOCK (locks stable) -> RST_HOLD -> PREAMBLE (blanking) -> RUN.
// Losing enable returns to IDLE. Losing either lock after WAIT_LOCK returns to WAIT_LOCK.
// Optional feature macro: DVI_SERDES_CTRL_LOSS_CNT_EN
//   Adds lock_loss_cnt, a saturating count of lock-forced exits, and its clear input lock_loss_clr.
module dvi_serdes_ctrl #(
  parameter int          LOCK_STABLE     = 64,
  parameter int          RST_CYCLES      = 16,
  parameter int          PREAMBLE_CYCLES = 1024,
  parameter logic [9:0]  BLANK_TOKEN     = 10'b1101010100
) (
  input  logic        gclk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pll_locked,
  input  logic        bufpll_locked,
  input  logic [29:0] tmds_in,
  output logic [29:0] tmds_out,
  output logic        serdes_reset,
  output logic        tx_ready,
`ifdef DVI_SERDES_CTRL_LOSS_CNT_EN
  input  logic        lock_loss_clr,
  output logic [7:0]  lock_loss_cnt,
`endif
  output logic [2:0]  state_out
);

  // A count of 0 behaves like 1, so every state lasts at least one cycle.
  localparam int LS   = (LOCK_STABLE     < 1) ? 1 : LOCK_STABLE;
  localparam int RC   = (RST_CYCLES      < 1) ? 1 : RST_CYCLES;
  localparam int PC   = (PREAMBLE_CYCLES < 1) ? 1 : PREAMBLE_CYCLES;
  localparam int M1   = (LS > RC) ? LS : RC;
  localparam int MAXC = (M1 > PC) ? M1 : PC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  // The counter loads N-1 and the state exits on the cycle it reads 0, giving N cycles.
  localparam logic [CW-1:0] LS_LD = CW'(LS - 1);
  localparam logic [CW-1:0] RC_LD = CW'(RC - 1);
  localparam logic [CW-1:0] PC_LD = CW'(PC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    RST_HOLD  = 3'd2,
    PREAMBLE  = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pll_s1, pll_s2, buf_s1, buf_s2;
  logic          lock_ok;
  logic          locked_state;

  // Two-flop synchronizers for the asynchronous lock inputs.
  always_ff @(posedge gclk or negedge reset_n) begin
    if (!reset_n) begin
      pll_s1 <= 1'b0;
      pll_s2 <= 1'b0;
      buf_s1 <= 1'b0;
      buf_s2 <= 1'b0;
    end else begin
      pll_s1 <= pll_locked;
      pll_s2 <= pll_s1;
      buf_s1 <= bufpll_locked;
      buf_s2 <= buf_s1;
    end
  end

  assign lock_ok      = pll_s2 & buf_s2;
  assign locked_state = (state == RST_HOLD) || (state == PREAMBLE) || (state == RUN);

  // Next-state and counter logic: enable first, then lock loss, then the normal flow.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    if (!enable) begin
      nxt     = IDLE;
      cnt_nxt = '0;
    end else if (!lock_ok && locked_state) begin
      nxt     = WAIT_LOCK;
      cnt_nxt = LS_LD;
    end else begin
      case (state)
        IDLE: begin
          nxt     = WAIT_LOCK;
          cnt_nxt = LS_LD;
        end
        WAIT_LOCK: begin
          if (!lock_ok)          cnt_nxt = LS_LD;
          else if (cnt == '0) begin
            nxt     = RST_HOLD;
            cnt_nxt = RC_LD;
          end else               cnt_nxt = cnt - 1'b1;
        end
        RST_HOLD: begin
          if (cnt == '0) begin
            nxt     = PREAMBLE;
            cnt_nxt = PC_LD;
          end else cnt_nxt = cnt - 1'b1;
        end
        PREAMBLE: begin
          if (cnt == '0) begin
            nxt     = RUN;
            cnt_nxt = '0;
          end else cnt_nxt = cnt - 1'b1;
        end
        RUN:     cnt_nxt = '0;
        default: begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs. Control outputs follow the next state,
  // while the word mux follows the current state and so lags the state change by one cycle.
  always_ff @(posedge gclk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      serdes_reset <= 1'b1;
      tx_ready     <= 1'b0;
      tmds_out     <= {3{BLANK_TOKEN}};
    end else begin
      state        <= nxt;
      cnt          <= cnt_nxt;
      serdes_reset <= !((nxt == PREAMBLE) || (nxt == RUN));
      tx_ready     <= (nxt == RUN);
      tmds_out     <= (state == RUN) ? tmds_in : {3{BLANK_TOKEN}};
    end
  end

  assign state_out = state;

`ifdef DVI_SERDES_CTRL_LOSS_CNT_EN
  logic lock_loss;
  assign lock_loss = enable && !lock_ok && locked_state;

  // Saturating lock-loss counter. A clear takes priority over a same-cycle increment.
  always_ff @(posedge gclk or negedge reset_n) begin
    if (!reset_n)                               lock_loss_cnt <= 8'd0;
    else if (lock_loss_clr)                     lock_loss_cnt <= 8'd0;
    else if (lock_loss && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/dvi_serdes_ctrl.md
Name: dvi_serdes_ctrl

Overview:
- Bring-up and supervision sequencer for the three TMDS data lanes and the clock lane built on OSERDES2 master/slave serializer pairs.
- Waits for the PLL and BUFPLL locks to be stable, holds the serializer reset, then sends a blanking-token preamble.
- Only after the preamble does it pass encoder words to the serializers.
- Any loss of lock restarts the sequence.
- Sits between the TMDS encoders and the serializer instances in the DVI output path, in the gclk (pixel-rate word) domain.

Parameters:
- LOCK_STABLE, 64: gclk cycles both locks must stay high continuously before the sequence advances.
- RST_CYCLES, 16: gclk cycles serdes_reset is held asserted after locks are stable.
- PREAMBLE_CYCLES, 1024: gclk cycles of BLANK_TOKEN sent on all lanes before RUN.
- BLANK_TOKEN, 10'b1101010100: TMDS control token for C1C0=00.

Ports:
- gclk  in  1  word clock; all logic runs on it.
- reset_n  in  1  asynchronous active-low reset; reset is asynchronous and active-low.
- enable  in  1  software enable; level-sensitive.
- pll_locked  in  1  PLL lock; asynchronous, synchronized internally.
- bufpll_locked  in  1  BUFPLL lock; asynchronous, synchronized internally.
- tmds_in  in  30  encoder words, lane0=[9:0], lane1=[19:10], lane2=[29:20].
- tmds_out  out  30  words to the serializers, same lane packing.
- serdes_reset  out  1  active-high reset to all serializer instances.
- tx_ready  out  1  high only in RUN.
- state_out  out  3  current state encoding, for debug.

Behaviour:
- Reset values: serdes_reset=1, tmds_out={3{BLANK_TOKEN}}, tx_ready=0, state=IDLE, counter=0, synchronizer flops=0.
- Lock inputs pass through 2-flop synchronizers. lock_ok = pll_sync & bufpll_sync.
- One down-counter is shared by all states. It is reloaded on every state entry.
- States and encodings:
  - IDLE=0: serdes_reset=1. Go to WAIT_LOCK when enable=1.
  - WAIT_LOCK=1: serdes_reset=1. The counter counts lock_ok-high cycles and reloads whenever lock_ok=0. Go to RST_HOLD after LOCK_STABLE consecutive high cycles.
  - RST_HOLD=2: serdes_reset=1 for exactly RST_CYCLES cycles, then go to PREAMBLE.
  - PREAMBLE=3: serdes_reset=0, tmds_out={3{BLANK_TOKEN}}. Go to RUN after exactly PREAMBLE_CYCLES cycles.
  - RUN=4: serdes_reset=0, tx_ready=1, tmds_out=tmds_in registered (1-cycle latency).
- Priority on every cycle: enable=0 first, then lock_ok=0, then the normal transition.
  - enable=0 in any state: next state IDLE.
  - lock_ok=0 in RST_HOLD, PREAMBLE or RUN: next state WAIT_LOCK.
  - In both cases serdes_reset is registered 1 and tx_ready 0 on the next edge.
- tmds_out is BLANK_TOKEN on all lanes in every state except RUN.
- The mux is registered, so tmds_out changes to or from blanking one cycle after the state change.
- Counter width is clog2 of the largest count parameter. A count parameter of 0 is treated as 1.
- reset_n assertion mid-operation forces reset values immediately (async). Release is synchronous to gclk through the normal state flow.
- Unused state encodings 5..7 go to IDLE.

Optional Feature:
- Macro: DVI_SERDES_CTRL_LOSS_CNT_EN.
- With the macro defined:
  - Adds output lock_loss_cnt [7:0]. It increments on every lock_ok-forced exit from RST_HOLD, PREAMBLE or RUN and saturates at 255.
  - Adds input lock_loss_clr [0:0]. A pulse clears the count to 0; clear wins over a simultaneous increment.
  - lock_loss_cnt resets to 0.
- Without the macro: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset release, enable=1, both locks high from cycle 0 → serdes_reset deasserts 2+64+16 cycles (±1 for the synchronizer) after enable, BLANK_TOKEN 0x354 for 1024 cycles, then tx_ready=1. tmds_in=0x3FF_000_2AA appears on tmds_out one cycle later.
- bufpll_locked pulses low for 1 cycle at cycle 40 of WAIT_LOCK → stability count restarts, and RST_HOLD entry is delayed by ≥40 cycles.
- pll_locked drops in RUN → within 3 cycles serdes_reset=1, tx_ready=0, tmds_out=BLANK_TOKEN, state=1. The full sequence repeats once the lock returns.
- enable=0 during PREAMBLE → state=0 and serdes_reset=1 on the next synchronized edge. Re-enable restarts at WAIT_LOCK.
- reset_n asserted mid-RUN with gclk stopped → all outputs reach reset values immediately.
- With LOSS_CNT_EN: 300 lock drops in RUN → lock_loss_cnt=255. lock_loss_clr and a drop in the same cycle → 0.
